// File: rtl/l2_interco_pkg.sv
// Shared types for the L2 interconnect: response tag carried alongside in-flight SRAM accesses.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Build option: L2_BANK_WR_RESP_EN adds an is_read bit to the tag so write responses carry zero data.
package l2_interco_pkg;

    localparam int MAX_MEM_LATENCY = 4;
    localparam int STALL_CNT_WIDTH = 16;
    localparam int L2_ID_WIDTH     = 20;

    typedef struct packed {
        logic                   valid;
`ifdef L2_BANK_WR_RESP_EN
        logic                   is_read;
`endif
        logic [L2_ID_WIDTH-1:0] id;
    } l2_resp_tag_t;

endpackage

// File: rtl/l2_resp_tag_pipe.sv
// Fixed-depth delay line for response tags; shared with the response router.
// Latency: DEPTH cycles from i_tag to o_tag.
// Backpressure: none, shifts every cycle.
// Ports: clk/rst (sync, active-high), i_tag in, o_tag = tag delayed by DEPTH cycles.
module l2_resp_tag_pipe
    import l2_interco_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  l2_resp_tag_t i_tag,
    output l2_resp_tag_t o_tag
);

    l2_resp_tag_t r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/l2_bank_mem_adapter.sv
// Adapts the arbitrated L2 bank request stream onto one single-port SRAM and returns read responses.
// Latency: requests pass straight to the SRAM; responses after MEM_LATENCY (+1 when OUT_REG=1) cycles.
// Backpressure: grant drops only for reset or mem_busy_i; responses cannot be stalled.
// Ports: data_* request/grant/response toward the interconnect, mem_* toward the SRAM macro,
//        stall_cnt_o saturating count of requested-but-not-granted cycles.
// Build option: L2_BANK_WR_RESP_EN makes writes respond too (with zero data).
module l2_bank_mem_adapter
    import l2_interco_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 64,
    parameter int BE_WIDTH    = DATA_WIDTH/8,
    parameter int ID_WIDTH    = 20,
    parameter int MEM_LATENCY = 1,
    parameter int OUT_REG     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_req_i,
    input  logic [ADDR_WIDTH-1:0]      data_add_i,
    input  logic                       data_wen_i,
    input  logic [DATA_WIDTH-1:0]      data_wdata_i,
    input  logic [BE_WIDTH-1:0]        data_be_i,
    input  logic [ID_WIDTH-1:0]        data_ID_i,
    output logic                       data_gnt_o,
    output logic                       data_r_valid_o,
    output logic [DATA_WIDTH-1:0]      data_r_rdata_o,
    output logic [ID_WIDTH-1:0]        data_r_ID_o,
    input  logic                       mem_busy_i,
    output logic                       mem_csn_o,
    output logic                       mem_wen_o,
    output logic [ADDR_WIDTH-1:0]      mem_add_o,
    output logic [DATA_WIDTH-1:0]      mem_wdata_o,
    output logic [BE_WIDTH-1:0]        mem_be_o,
    input  logic [DATA_WIDTH-1:0]      mem_rdata_i,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

    // Keep the tag pipe inside the depth range the SRAM macros support.
    localparam int LAT = (MEM_LATENCY < 1) ? 1 :
                         (MEM_LATENCY > MAX_MEM_LATENCY) ? MAX_MEM_LATENCY : MEM_LATENCY;

    logic                       w_issue;
    l2_resp_tag_t               w_tag_in;
    l2_resp_tag_t               w_tag_out;
    logic                       w_rsp_vld;
    logic                       w_rsp_has_data;
    logic [DATA_WIDTH-1:0]      w_rsp_dat;
    logic [ID_WIDTH-1:0]        w_rsp_id;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    // Grant ignores data_req_i so the upstream round-robin can advance on req&gnt without a loop.
    assign data_gnt_o  = ~rst & ~mem_busy_i;
    assign w_issue     = data_req_i & data_gnt_o;

    assign mem_csn_o   = ~w_issue;
    assign mem_wen_o   = ~(w_issue & ~data_wen_i);
    assign mem_add_o   = data_add_i;
    assign mem_wdata_o = data_wdata_i;
    // Zero byte enables when idle so stale write data can never land in the bank.
    assign mem_be_o    = w_issue ? data_be_i : '0;

    always_comb begin
        w_tag_in = '0;
`ifdef L2_BANK_WR_RESP_EN
        w_tag_in.valid   = w_issue;
        w_tag_in.is_read = data_wen_i;
`else
        w_tag_in.valid   = w_issue & data_wen_i;
`endif
        w_tag_in.id = L2_ID_WIDTH'(data_ID_i);
    end

    l2_resp_tag_pipe #(
        .DEPTH (LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign w_rsp_vld = w_tag_out.valid;
    assign w_rsp_id  = ID_WIDTH'(w_tag_out.id);
`ifdef L2_BANK_WR_RESP_EN
    assign w_rsp_has_data = w_tag_out.valid & w_tag_out.is_read;
`else
    assign w_rsp_has_data = w_tag_out.valid;
`endif
    assign w_rsp_dat = w_rsp_has_data ? mem_rdata_i : '0;

    if (OUT_REG != 0) begin : g_out_reg
        logic                  r_rsp_vld;
        logic [DATA_WIDTH-1:0] r_rsp_dat;
        logic [ID_WIDTH-1:0]   r_rsp_id;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rsp_vld <= 1'b0;
                r_rsp_dat <= '0;
                r_rsp_id  <= '0;
            end else begin
                r_rsp_vld <= w_rsp_vld;
                r_rsp_dat <= w_rsp_dat;
                r_rsp_id  <= w_rsp_id;
            end
        end

        assign data_r_valid_o = r_rsp_vld;
        assign data_r_rdata_o = r_rsp_dat;
        assign data_r_ID_o    = r_rsp_id;
    end else begin : g_out_comb
        assign data_r_valid_o = w_rsp_vld;
        assign data_r_rdata_o = w_rsp_dat;
        assign data_r_ID_o    = w_rsp_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (data_req_i && !data_gnt_o && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;

endmodule
